// File: rtl/sccb_config_seq.sv
// SCCB register-table sequencer.
// Walks a ROM of 18-bit entries and turns each one into a two-byte SCCB
// register write (register address, then value), a millisecond delay, a
// skip, or the end of the table. Every register write is watched by a
// timeout; if the timeout expires, the rest of the table is abandoned and
// err_out is raised.
module sccb_config_seq #(
    parameter int         CLK_IN_FREQ_MHZ = 10,
    parameter logic [6:0] DEV_ADDR        = 7'h30,
    parameter int         ROM_AW          = 8,
    parameter int         TIMEOUT_CYC     = 100000
) (
    input  logic              clk_in,
    input  logic              n_rst,
    input  logic              start_in,
    output logic [ROM_AW-1:0] rom_addr_out,
    input  logic [17:0]       rom_data_in,
    input  logic              sccb_ready_in,
    input  logic              sccb_wr_valid_in,
    output logic              sccb_enable_out,
    output logic              sccb_three_phase_out,
    output logic              sccb_rd_wr_out,
    output logic [6:0]        sccb_address_out,
    output logic [7:0]        sccb_wr_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // IDLE     | reset state, waits for start_in
    // FETCH    | rom_addr_out is stable, ROM output settles
    // DECODE   | rom_data_in is valid, entry latched and dispatched
    // WAIT_RDY | register write pending, waits for the master to be ready
    // ISSUE    | one-cycle sccb_enable_out request, register address shown
    // SEND_REG | waits for the first byte-done pulse (register address)
    // SEND_VAL | value byte shown, waits for the second byte-done pulse
    // DELAY    | counting out {a,b} milliseconds
    // DONE     | table finished or aborted, done_out held until next start

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_WAIT_RDY = 4'd3,
        S_ISSUE    = 4'd4,
        S_SEND_REG = 4'd5,
        S_SEND_VAL = 4'd6,
        S_DELAY    = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_NOP   = 2'b10;

    // One millisecond of clk_in cycles; the prescaler counts it down.
    localparam int              PRE_CYC  = CLK_IN_FREQ_MHZ * 1000;
    localparam int              PRE_W    = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRE_CYC - 1);

    // The write timeout counts down from TIMEOUT_CYC-1; reaching zero while a
    // write is still in flight is the abort condition.
    localparam int             TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    state_t state_q;
    state_t state_d;

    logic [7:0]       entry_a_q;
    logic [7:0]       entry_b_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [15:0]      ms_cnt_q;
    logic             err_q;
    logic [7:0]       wr_data_q;
    logic [ROM_AW-1:0] addr_q;

    logic [1:0]  entry_op;
    logic [15:0] entry_cnt;
    logic        to_expired;
    logic        to_active;
    logic        pre_tc;
    logic        ms_tc;

    logic seq_start;
    logic addr_inc;
    logic to_load;
    logic dly_load;
    logic wr_load_a;
    logic wr_load_b;
    logic err_set;

    assign entry_op   = rom_data_in[17:16];
    assign entry_cnt  = rom_data_in[15:0];
    assign to_expired = (to_cnt_q == '0);
    assign pre_tc     = (pre_cnt_q == '0);
    assign ms_tc      = (ms_cnt_q == 16'd0);
    assign to_active  = (state_q == S_WAIT_RDY) || (state_q == S_ISSUE) ||
                        (state_q == S_SEND_REG) || (state_q == S_SEND_VAL);

    // State register; reset drops any request to the master immediately.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the one-cycle datapath strobes for each transition.
    always_comb begin
        state_d   = state_q;
        seq_start = 1'b0;
        addr_inc  = 1'b0;
        to_load   = 1'b0;
        dly_load  = 1'b0;
        wr_load_a = 1'b0;
        wr_load_b = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    seq_start = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (entry_op)
                    OP_WRITE: begin
                        to_load = 1'b1;
                        state_d = S_WAIT_RDY;
                    end
                    OP_DELAY: begin
                        if (entry_cnt != 16'd0) begin
                            dly_load = 1'b1;
                            state_d  = S_DELAY;
                        end else begin
                            addr_inc = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    OP_NOP: begin
                        addr_inc = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WAIT_RDY: begin
                if (to_expired) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end else if (sccb_ready_in) begin
                    wr_load_a = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (to_expired) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SEND_REG;
                end
            end
            S_SEND_REG: begin
                if (to_expired) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end else if (sccb_wr_valid_in) begin
                    wr_load_b = 1'b1;
                    state_d   = S_SEND_VAL;
                end
            end
            S_SEND_VAL: begin
                if (to_expired) begin
                    err_set = 1'b1;
                    state_d = S_DONE;
                end else if (sccb_wr_valid_in) begin
                    addr_inc = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_DELAY: begin
                if (pre_tc && ms_tc) begin
                    addr_inc = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Table address: cleared on start, advanced after each completed entry,
    // wraps naturally at the top of the address space.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            addr_q <= '0;
        end else if (seq_start) begin
            addr_q <= '0;
        end else if (addr_inc) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // Entry operands captured while the ROM output is valid in DECODE.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            entry_a_q <= 8'd0;
            entry_b_q <= 8'd0;
        end else if (state_q == S_DECODE) begin
            entry_a_q <= rom_data_in[15:8];
            entry_b_q <= rom_data_in[7:0];
        end
    end

    // Byte shown to the master: register address on issue, value after the
    // first byte-done pulse; otherwise held so the master sees a stable byte.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            wr_data_q <= 8'd0;
        end else if (wr_load_a) begin
            wr_data_q <= entry_a_q;
        end else if (wr_load_b) begin
            wr_data_q <= entry_b_q;
        end
    end

    // Sticky timeout flag, cleared only by a new start.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else if (seq_start) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    // Write timeout down-counter: loaded on the way into WAIT_RDY, then
    // decremented every cycle the write is in flight.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt_q <= '0;
        end else if (to_load) begin
            to_cnt_q <= TO_LOAD;
        end else if (to_active && !to_expired) begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end

    // Delay timer: millisecond down-counter stepped by a one-millisecond
    // prescaler, so a count of N holds DELAY for exactly N*PRE_CYC cycles.
    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            pre_cnt_q <= '0;
            ms_cnt_q  <= 16'd0;
        end else if (dly_load) begin
            pre_cnt_q <= PRE_LOAD;
            ms_cnt_q  <= entry_cnt - 16'd1;
        end else if (state_q == S_DELAY) begin
            if (!pre_tc) begin
                pre_cnt_q <= pre_cnt_q - 1'b1;
            end else if (!ms_tc) begin
                pre_cnt_q <= PRE_LOAD;
                ms_cnt_q  <= ms_cnt_q - 16'd1;
            end
        end
    end

    assign rom_addr_out         = addr_q;
    assign sccb_wr_data_out     = wr_data_q;
    assign err_out              = err_q;
    assign sccb_enable_out      = (state_q == S_ISSUE);
    assign busy_out             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_out             = (state_q == S_DONE);
    assign sccb_three_phase_out = 1'b1;
    assign sccb_rd_wr_out       = 1'b0;
    assign sccb_address_out     = DEV_ADDR;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench for sccb_config_seq: ROM model, simple SCCB master model,
// and one task per scenario with hand-computed expected values.
module tb_sccb_config_seq;

    logic        clk_in = 1'b0;
    logic        n_rst = 1'b0;
    logic        start_in = 1'b0;
    logic [7:0]  rom_addr_out;
    logic [17:0] rom_data_in;
    logic        sccb_ready_in = 1'b0;
    logic        sccb_wr_valid_in;
    logic        sccb_enable_out;
    logic        sccb_three_phase_out;
    logic        sccb_rd_wr_out;
    logic [6:0]  sccb_address_out;
    logic [7:0]  sccb_wr_data_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    logic        man_valid = 1'b0;
    logic        mst_valid = 1'b0;
    logic        master_on = 1'b0;
    logic [17:0] rom [256];
    logic [7:0]  wr_log [$];
    int          en_count = 0;
    int          vectors = 0;
    int          miscompares = 0;

    assign sccb_wr_valid_in = man_valid | mst_valid;

    sccb_config_seq #(
        .CLK_IN_FREQ_MHZ(10),
        .DEV_ADDR(7'h30),
        .ROM_AW(8),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk_in(clk_in),
        .n_rst(n_rst),
        .start_in(start_in),
        .rom_addr_out(rom_addr_out),
        .rom_data_in(rom_data_in),
        .sccb_ready_in(sccb_ready_in),
        .sccb_wr_valid_in(sccb_wr_valid_in),
        .sccb_enable_out(sccb_enable_out),
        .sccb_three_phase_out(sccb_three_phase_out),
        .sccb_rd_wr_out(sccb_rd_wr_out),
        .sccb_address_out(sccb_address_out),
        .sccb_wr_data_out(sccb_wr_data_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous ROM: data valid one cycle after the address changes.
    always @(posedge clk_in) rom_data_in <= rom[rom_addr_out];

    // Counts enable cycles; a pulse wider than one cycle shows up as extra counts.
    always @(negedge clk_in) if (sccb_enable_out === 1'b1) en_count++;

    // Master model: on enable, logs the byte shown, pulses byte-done after
    // 3 cycles, then logs the byte shown and pulses again 4 cycles later.
    always begin
        @(negedge clk_in);
        if (master_on && sccb_enable_out === 1'b1) begin
            wr_log.push_back(sccb_wr_data_out);
            repeat (3) @(negedge clk_in);
            mst_valid = 1'b1;
            @(negedge clk_in);
            mst_valid = 1'b0;
            repeat (4) @(negedge clk_in);
            wr_log.push_back(sccb_wr_data_out);
            mst_valid = 1'b1;
            @(negedge clk_in);
            mst_valid = 1'b0;
        end
    end

    task automatic fill_rom(input logic [17:0] val);
        for (int i = 0; i < 256; i++) rom[i] = val;
    endtask

    // Start pulse caught by exactly one rising edge (E0); returns at E0+1.
    task automatic pulse_start();
        @(negedge clk_in);
        start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
    endtask

    // Returns the index of the first edge after E0 at which done_out is seen,
    // or limit+1 when it never appears.
    task automatic wait_done(input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk_in);
            #1;
            if (done_out === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_out); end
        vectors++; if (done_out !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done_out); end
        vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err_out); end
        vectors++; if (sccb_enable_out !== 1'b0) begin miscompares++; $display("FAIL rst_enable: got %b want 0", sccb_enable_out); end
        vectors++; if (rom_addr_out !== 8'h00) begin miscompares++; $display("FAIL rst_addr: got %h want 00", rom_addr_out); end
        vectors++; if (sccb_wr_data_out !== 8'h00) begin miscompares++; $display("FAIL rst_wr_data: got %h want 00", sccb_wr_data_out); end
        vectors++; if (sccb_three_phase_out !== 1'b1) begin miscompares++; $display("FAIL rst_three_phase: got %b want 1", sccb_three_phase_out); end
        vectors++; if (sccb_rd_wr_out !== 1'b0) begin miscompares++; $display("FAIL rst_rd_wr: got %b want 0", sccb_rd_wr_out); end
        vectors++; if (sccb_address_out !== 7'h30) begin miscompares++; $display("FAIL rst_dev_addr: got %h want 30", sccb_address_out); end
        n_rst = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        vectors++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin miscompares++; $display("FAIL idle_after_release: busy %b done %b want 0 0", busy_out, done_out); end
    endtask

    task automatic test_write_seq();
        logic [7:0] exp_log [4];
        int n;
        int en0;
        exp_log = '{8'hFF, 8'h01, 8'h12, 8'h80};
        fill_rom(18'h3_0000);
        rom[0] = {2'b00, 8'hFF, 8'h01};
        rom[1] = {2'b00, 8'h12, 8'h80};
        rom[2] = {2'b11, 16'h0000};
        master_on = 1'b1;
        sccb_ready_in = 1'b1;
        wr_log.delete();
        en0 = en_count;
        pulse_start();
        n = 201;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk_in);
            #1;
            start_in = (i == 10);
            if (i == 12) begin
                vectors++; if (busy_out !== 1'b1) begin miscompares++; $display("FAIL mid_start_busy: got %b want 1", busy_out); end
                vectors++; if (rom_addr_out !== 8'h01) begin miscompares++; $display("FAIL mid_start_addr: got %h want 01", rom_addr_out); end
            end
            if (done_out === 1'b1) begin
                n = i;
                break;
            end
        end
        start_in = 1'b0;
        vectors++; if (n !== 26) begin miscompares++; $display("FAIL write_done_cycle: got %0d want 26", n); end
        vectors++; if (en_count - en0 !== 2) begin miscompares++; $display("FAIL write_enable_pulses: got %0d want 2", en_count - en0); end
        vectors++;
        if (wr_log.size() !== 4) begin
            miscompares++; $display("FAIL write_byte_count: got %0d want 4", wr_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr_log[k] !== exp_log[k]) begin
                    miscompares++; $display("FAIL write_byte_%0d: got %h want %h", k, wr_log[k], exp_log[k]);
                end
            end
        end
        vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL write_err: got %b want 0", err_out); end
        vectors++; if (rom_addr_out !== 8'h02) begin miscompares++; $display("FAIL write_addr: got %h want 02", rom_addr_out); end
        vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL write_busy_end: got %b want 0", busy_out); end
        repeat (5) @(posedge clk_in);
        #1;
        vectors++; if (done_out !== 1'b1) begin miscompares++; $display("FAIL done_level_hold: got %b want 1", done_out); end
    endtask

    task automatic test_delay();
        int n;
        int en0;
        fill_rom(18'h3_0000);
        rom[0] = {2'b01, 16'h0002};
        rom[1] = {2'b11, 16'h0000};
        en0 = en_count;
        pulse_start();
        n = 30001;
        for (int i = 1; i <= 30000; i++) begin
            @(posedge clk_in);
            #1;
            start_in = (i == 100);
            if (i == 101) begin
                vectors++; if (busy_out !== 1'b1 || rom_addr_out !== 8'h00) begin miscompares++; $display("FAIL delay_start_ignored: busy %b addr %h want 1 00", busy_out, rom_addr_out); end
            end
            if (i == 20001) begin
                vectors++; if (rom_addr_out !== 8'h00) begin miscompares++; $display("FAIL delay_last_cycle_addr: got %h want 00", rom_addr_out); end
            end
            if (i == 20002) begin
                vectors++; if (rom_addr_out !== 8'h01) begin miscompares++; $display("FAIL delay_exit_addr: got %h want 01", rom_addr_out); end
            end
            if (done_out === 1'b1) begin
                n = i;
                break;
            end
        end
        start_in = 1'b0;
        vectors++; if (n !== 20004) begin miscompares++; $display("FAIL delay_done_cycle: got %0d want 20004", n); end
        vectors++; if (en_count - en0 !== 0) begin miscompares++; $display("FAIL delay_enable: got %0d want 0", en_count - en0); end
        vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL delay_err: got %b want 0", err_out); end
    endtask

    task automatic test_nop_zero();
        int n;
        int en0;
        fill_rom(18'h3_0000);
        rom[0] = {2'b10, 16'h1234};
        rom[1] = {2'b01, 16'h0000};
        rom[2] = {2'b11, 16'h0000};
        en0 = en_count;
        pulse_start();
        wait_done(100, n);
        vectors++; if (n !== 6) begin miscompares++; $display("FAIL nop_zero_done_cycle: got %0d want 6", n); end
        vectors++; if (rom_addr_out !== 8'h02) begin miscompares++; $display("FAIL nop_zero_addr: got %h want 02", rom_addr_out); end
        vectors++; if (en_count - en0 !== 0) begin miscompares++; $display("FAIL nop_zero_enable: got %0d want 0", en_count - en0); end
    endtask

    task automatic test_timeout();
        int n;
        int en0;
        fill_rom(18'h3_0000);
        rom[0] = {2'b00, 8'h30, 8'hAA};
        rom[1] = {2'b11, 16'h0000};
        master_on = 1'b0;
        sccb_ready_in = 1'b1;
        en0 = en_count;
        pulse_start();
        wait_done(200, n);
        // WAIT_RDY is entered at edge 2, so 50 cycles later is edge 52.
        vectors++; if (n !== 52) begin miscompares++; $display("FAIL timeout_done_cycle: got %0d want 52", n); end
        vectors++; if (err_out !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b want 1", err_out); end
        vectors++; if (busy_out !== 1'b0 || sccb_enable_out !== 1'b0) begin miscompares++; $display("FAIL timeout_idle: busy %b enable %b want 0 0", busy_out, sccb_enable_out); end
        vectors++; if (rom_addr_out !== 8'h00) begin miscompares++; $display("FAIL timeout_addr: got %h want 00", rom_addr_out); end
        vectors++; if (sccb_wr_data_out !== 8'h30) begin miscompares++; $display("FAIL timeout_wr_data: got %h want 30", sccb_wr_data_out); end
        vectors++; if (en_count - en0 !== 1) begin miscompares++; $display("FAIL timeout_enable: got %0d want 1", en_count - en0); end
    endtask

    task automatic test_ready_wait();
        int n;
        int en0;
        fill_rom(18'h3_0000);
        rom[0] = {2'b00, 8'h55, 8'h66};
        rom[1] = {2'b11, 16'h0000};
        master_on = 1'b1;
        sccb_ready_in = 1'b0;
        wr_log.delete();
        en0 = en_count;
        pulse_start();
        n = 201;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk_in);
            #1;
            if (i == 1) begin
                vectors++; if (err_out !== 1'b0 || done_out !== 1'b0 || busy_out !== 1'b1) begin miscompares++; $display("FAIL restart_flags: err %b done %b busy %b want 0 0 1", err_out, done_out, busy_out); end
            end
            if (i == 20) begin
                vectors++; if (en_count - en0 !== 0) begin miscompares++; $display("FAIL ready_hold_enable: got %0d want 0", en_count - en0); end
                sccb_ready_in = 1'b1;
            end
            if (done_out === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++; if (n !== 32) begin miscompares++; $display("FAIL ready_done_cycle: got %0d want 32", n); end
        vectors++;
        if (wr_log.size() !== 2) begin
            miscompares++; $display("FAIL ready_byte_count: got %0d want 2", wr_log.size());
        end else if (wr_log[0] !== 8'h55 || wr_log[1] !== 8'h66) begin
            miscompares++; $display("FAIL ready_bytes: got %h %h want 55 66", wr_log[0], wr_log[1]);
        end
        vectors++; if (err_out !== 1'b0) begin miscompares++; $display("FAIL ready_err: got %b want 0", err_out); end
    endtask

    task automatic test_wrap();
        int n;
        fill_rom(18'h2_0000);
        pulse_start();
        n = 601;
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk_in);
            #1;
            if (i == 300) rom[1] = 18'h3_0000;
            if (i == 511) begin
                vectors++; if (rom_addr_out !== 8'hFF) begin miscompares++; $display("FAIL wrap_top_addr: got %h want ff", rom_addr_out); end
            end
            if (i == 512) begin
                vectors++; if (rom_addr_out !== 8'h00) begin miscompares++; $display("FAIL wrap_zero_addr: got %h want 00", rom_addr_out); end
            end
            if (done_out === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++; if (n !== 516) begin miscompares++; $display("FAIL wrap_done_cycle: got %0d want 516", n); end
        vectors++; if (rom_addr_out !== 8'h01 || err_out !== 1'b0) begin miscompares++; $display("FAIL wrap_end: addr %h err %b want 01 0", rom_addr_out, err_out); end
    endtask

    task automatic test_reset_mid();
        int n;
        int en0;
        fill_rom(18'h3_0000);
        rom[0] = {2'b00, 8'hFF, 8'h01};
        rom[1] = {2'b11, 16'h0000};
        master_on = 1'b0;
        sccb_ready_in = 1'b1;
        // Reset while the enable request is up.
        pulse_start();
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_in);
            #1;
            if (sccb_enable_out === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++; if (n !== 3) begin miscompares++; $display("FAIL issue_cycle: got %0d want 3", n); end
        #2 n_rst = 1'b0;
        #1;
        vectors++; if (sccb_enable_out !== 1'b0 || busy_out !== 1'b0) begin miscompares++; $display("FAIL rst_in_issue: enable %b busy %b want 0 0", sccb_enable_out, busy_out); end
        #2 n_rst = 1'b1;
        // Reset in SEND_VAL.
        pulse_start();
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_in);
            #1;
            if (sccb_enable_out === 1'b1) begin
                n = i;
                break;
            end
        end
        @(posedge clk_in);
        #1 man_valid = 1'b1;
        @(posedge clk_in);
        #1 man_valid = 1'b0;
        vectors++; if (sccb_wr_data_out !== 8'h01 || busy_out !== 1'b1) begin miscompares++; $display("FAIL send_val_state: wr_data %h busy %b want 01 1", sccb_wr_data_out, busy_out); end
        @(posedge clk_in);
        #3 n_rst = 1'b0;
        #1;
        vectors++; if (sccb_enable_out !== 1'b0 || busy_out !== 1'b0 || rom_addr_out !== 8'h00) begin miscompares++; $display("FAIL rst_in_send_val: enable %b busy %b addr %h want 0 0 00", sccb_enable_out, busy_out, rom_addr_out); end
        vectors++; if (sccb_wr_data_out !== 8'h00 || done_out !== 1'b0 || err_out !== 1'b0) begin miscompares++; $display("FAIL rst_in_send_val_out: wr_data %h done %b err %b want 00 0 0", sccb_wr_data_out, done_out, err_out); end
        vectors++; if (sccb_three_phase_out !== 1'b1 || sccb_rd_wr_out !== 1'b0 || sccb_address_out !== 7'h30) begin miscompares++; $display("FAIL rst_const_out: tp %b rw %b dev %h want 1 0 30", sccb_three_phase_out, sccb_rd_wr_out, sccb_address_out); end
        #2 n_rst = 1'b1;
        // Stray byte-done pulse while idle must do nothing.
        @(posedge clk_in);
        #1 man_valid = 1'b1;
        @(posedge clk_in);
        #1 man_valid = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        vectors++; if (busy_out !== 1'b0 || done_out !== 1'b0 || rom_addr_out !== 8'h00 || sccb_wr_data_out !== 8'h00) begin miscompares++; $display("FAIL idle_stray_valid: busy %b done %b addr %h wr %h want 0 0 00 00", busy_out, done_out, rom_addr_out, sccb_wr_data_out); end
        // Fresh run from entry 0.
        master_on = 1'b1;
        en0 = en_count;
        pulse_start();
        wait_done(100, n);
        vectors++; if (n !== 14) begin miscompares++; $display("FAIL rerun_done_cycle: got %0d want 14", n); end
        vectors++; if (rom_addr_out !== 8'h01 || err_out !== 1'b0) begin miscompares++; $display("FAIL rerun_end: addr %h err %b want 01 0", rom_addr_out, err_out); end
        vectors++; if (en_count - en0 !== 1) begin miscompares++; $display("FAIL rerun_enable: got %0d want 1", en_count - en0); end
        master_on = 1'b0;
    endtask

    initial begin
        fill_rom(18'h3_0000);
        test_reset();
        test_write_seq();
        test_delay();
        test_nop_zero();
        test_timeout();
        test_ready_wait();
        test_wrap();
        test_reset_mid();
        repeat (12) @(posedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
